// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the programmable clock divider.
// Ratios are carried as int unsigned so the helpers serve any WIDTH.
package clk_div_pkg;

  localparam int unsigned DIV_MIN = 2;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic int unsigned half_of(input int unsigned n);
    return n >> 1;
  endfunction

  function automatic logic is_odd(input int unsigned n);
    return n[0];
  endfunction

endpackage

// File: rtl/clk_div_ratio_ctl.sv
// Ratio shadow register: captures legal loads, flags illegal ones, and
// drops the pending flag when the core consumes the shadow at a boundary.
module clk_div_ratio_ctl
  import clk_div_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned DEFAULT_DIV = 7
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic [WIDTH-1:0] div,
  input  logic             div_load,
  input  logic             apply,
  output logic [WIDTH-1:0] shadow,
  output logic             pending,
  output logic             load_err
);

  logic legal;

  assign legal = 32'(div) >= DIV_MIN;

  // A legal load on the apply edge re-arms pending: the core takes the old
  // shadow at this boundary and the new value at the next one.
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      shadow   <= WIDTH'(DEFAULT_DIV);
      pending  <= 1'b0;
      load_err <= 1'b0;
    end else begin
      load_err <= div_load & ~legal;
      if (div_load && legal) begin
        shadow  <= div;
        pending <= 1'b1;
      end else if (apply) begin
        pending <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/prog_clk_div.sv
// Runtime-programmable 50%-duty integer clock divider; ratio changes take
// effect only at a period boundary, and the enable parks the output low.
module prog_clk_div
  import clk_div_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned DEFAULT_DIV = 7
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] div,
  input  logic             div_load,
  output logic             clk_out,
  output logic             period_start,
  output logic             ratio_ack,
  output logic             load_err
);

  if (64'(DEFAULT_DIV) < 64'(DIV_MIN) ||
      64'(DEFAULT_DIV) > ((64'(1) << WIDTH) - 64'(1))) begin : g_bad_default
    $error("prog_clk_div: DEFAULT_DIV outside 2..2^WIDTH-1");
  end

  state_t           state, state_n;
  logic [WIDTH-1:0] active, active_n;
  logic [WIDTH-1:0] cnt, cnt_n;
  logic             clkp, clkp_n;
  logic             clkn;
  logic             period_start_n, ratio_ack_n;
  logic             apply;
  logic [WIDTH-1:0] shadow;
  logic             pending;

  clk_div_ratio_ctl #(
    .WIDTH      (WIDTH),
    .DEFAULT_DIV(DEFAULT_DIV)
  ) u_ratio_ctl (
    .clk_in  (clk_in),
    .rst     (rst),
    .div     (div),
    .div_load(div_load),
    .apply   (apply),
    .shadow  (shadow),
    .pending (pending),
    .load_err(load_err)
  );

  always_comb begin
    state_n        = state;
    cnt_n          = cnt;
    active_n       = active;
    clkp_n         = clkp;
    apply          = 1'b0;
    period_start_n = 1'b0;
    ratio_ack_n    = 1'b0;
    case (state)
      IDLE: begin
        if (en) apply = 1'b1;
      end
      RUN: begin
        if (cnt == active - WIDTH'(1)) begin
          if (en) begin
            apply = 1'b1;
          end else begin
            state_n = IDLE;
            clkp_n  = 1'b0;
          end
        end else begin
          cnt_n  = cnt + WIDTH'(1);
          clkp_n = 32'(cnt_n) < half_of(32'(active));
        end
      end
      default: state_n = IDLE;
    endcase
    // Start of a new period: the whole period runs on the (possibly new) ratio.
    if (apply) begin
      state_n        = RUN;
      cnt_n          = '0;
      clkp_n         = 1'b1;
      period_start_n = 1'b1;
      ratio_ack_n    = pending;
      if (pending) active_n = shadow;
    end
  end

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      cnt          <= WIDTH'(DEFAULT_DIV - 1);
      active       <= WIDTH'(DEFAULT_DIV);
      clkp         <= 1'b0;
      period_start <= 1'b0;
      ratio_ack    <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      active       <= active_n;
      clkp         <= clkp_n;
      period_start <= period_start_n;
      ratio_ack    <= ratio_ack_n;
    end
  end

  // Half-cycle stretch of the high phase for odd ratios.
  always_ff @(negedge clk_in or negedge rst) begin
    if (!rst) clkn <= 1'b0;
    else      clkn <= is_odd(32'(active)) ? clkp : 1'b0;
  end

  assign clk_out = clkp | clkn;

endmodule

// File: tb/tb_prog_clk_div.sv
// Bench for prog_clk_div: directed ratio/enable/reset sequences, with a
// half-cycle monitor measuring each period against an expected queue.
module tb_prog_clk_div;

  localparam int W = 21;  // {ack, high half-cycles[9:0], total half-cycles[9:0]}

  logic       clk_in = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] div;
  logic       div_load;
  logic       clk_out, period_start, ratio_ack, load_err;

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int passes = 0;

  prog_clk_div #(.WIDTH(8), .DEFAULT_DIV(7)) dut (
    .clk_in      (clk_in),
    .rst         (rst),
    .en          (en),
    .div         (div),
    .div_load    (div_load),
    .clk_out     (clk_out),
    .period_start(period_start),
    .ratio_ack   (ratio_ack),
    .load_err    (load_err)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got == exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
  endtask

  // total == 0 marks a period that ends in IDLE, whose length is not checked.
  task automatic push(input int ack, input int high, input int total);
    logic [W-1:0] r;
    r[20]    = ack[0];
    r[19:10] = high[9:0];
    r[9:0]   = total[9:0];
    exp_q.push_back(r);
  endtask

  task automatic wait_ps(input string name);
    for (int i = 0; i < 600; i++) begin
      @(posedge clk_in); #1;
      if (period_start) return;
    end
    checks++;
    $display("FAIL %s: period_start not seen within 600 cycles", name);
  endtask

  task automatic do_load(input logic [7:0] v);
    div      = v;
    div_load = 1'b1;
    @(posedge clk_in); #1;
    div_load = 1'b0;
  endtask

  // Monitor: samples clk_out 1 time unit after every clock edge.
  logic         in_prog = 1'b0;
  logic         ack_r = 1'b0;
  int           high_h = 0;
  int           total_h = 0;
  int           rec_n = 0;
  logic [W-1:0] e;
  logic         ok;

  always begin
    @(clk_in); #1;
    if (!rst) begin
      in_prog = 1'b0;
    end else begin
      if (clk_in && period_start) begin
        if (in_prog) begin
          rec_n++;
          checks++;
          if (exp_q.size() == 0) begin
            $display("FAIL period_%0d: got ack=%0d high=%0d total=%0d, expected no period",
                     rec_n, ack_r, high_h, total_h);
          end else begin
            e  = exp_q.pop_front();
            ok = (e[20] == ack_r) && (e[19:10] == high_h[9:0]) &&
                 (e[9:0] == 10'd0 || e[9:0] == total_h[9:0]);
            if (ok) passes++;
            else $display("FAIL period_%0d: got ack=%0d high=%0d total=%0d, expected ack=%0d high=%0d total=%0d",
                          rec_n, ack_r, high_h, total_h, e[20], e[19:10], e[9:0]);
          end
        end
        in_prog = 1'b1;
        high_h  = 0;
        total_h = 0;
        ack_r   = ratio_ack;
      end
      if (in_prog) begin
        total_h++;
        if (clk_out) high_h++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic idle_bad;
    rst = 1'b0; en = 1'b0; div = '0; div_load = 1'b0;
    repeat (3) @(posedge clk_in);
    #1;
    check("reset_clk_out", clk_out, 0);
    check("reset_period_start", period_start, 0);
    check("reset_ratio_ack", ratio_ack, 0);
    check("reset_load_err", load_err, 0);

    // Default ratio 7: 3.5 cycles high out of 7.
    push(0, 7, 14); push(0, 7, 14); push(0, 7, 14);
    push(1, 4, 8);  push(0, 4, 8);
    #2; rst = 1'b1; en = 1'b1;
    @(posedge clk_in); #1;
    check("rise_latency_clk_out", clk_out, 1);
    check("rise_latency_period_start", period_start, 1);
    wait_ps("p2");
    wait_ps("p3");
    repeat (2) @(posedge clk_in);
    #1;
    do_load(8'd4);
    wait_ps("p4");
    wait_ps("p5");

    // 3, 2, then 255 loaded on the boundary of the first 2-cycle period.
    push(1, 3, 6); push(1, 2, 4); push(0, 2, 4); push(1, 255, 510);
    do_load(8'd3);
    wait_ps("p6");
    do_load(8'd2);
    wait_ps("p7");
    @(posedge clk_in); #1;
    do_load(8'd255);
    wait_ps("p9");

    // Illegal ratios are rejected and leave 255 in place.
    push(0, 255, 510);
    do_load(8'd1);
    check("load_err_div1", load_err, 1);
    do_load(8'd0);
    check("load_err_div0", load_err, 1);
    @(posedge clk_in); #1;
    check("load_err_clear", load_err, 0);
    wait_ps("p10");
    do_load(8'd6);
    wait_ps("p11");

    // Drop en at cnt=1 with N=6; the period completes, then idles low.
    push(1, 6, 0); push(0, 6, 12); push(0, 6, 12);
    @(posedge clk_in); #1;
    en = 1'b0;
    repeat (5) @(posedge clk_in);
    idle_bad = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk_in); #1;
      if (clk_out || period_start) idle_bad = 1'b1;
      @(negedge clk_in); #1;
      if (clk_out) idle_bad = 1'b1;
    end
    check("idle_low", idle_bad, 0);
    en = 1'b1;
    @(posedge clk_in); #1;
    check("reenable_clk_out", clk_out, 1);
    check("reenable_period_start", period_start, 1);
    wait_ps("p13");
    wait_ps("p14");

    // Reset while high with a load pending: output drops, pending is lost.
    do_load(8'd5);
    check("pre_reset_high", clk_out, 1);
    push(0, 7, 14); push(0, 7, 14);
    #2; rst = 1'b0;
    #1;
    check("reset_async_clk_out", clk_out, 0);
    check("reset_async_period_start", period_start, 0);
    repeat (3) @(posedge clk_in);
    #3; rst = 1'b1;
    @(posedge clk_in); #1;
    check("post_reset_clk_out", clk_out, 1);
    check("post_reset_ratio_ack", ratio_ack, 0);
    wait_ps("p16");
    wait_ps("p17");
    #2;
    check("queue_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
